// File: rtl/kbtx_pkg.sv
// Shared constants, FSM state encoding and source-select values for the
// keyboard-matrix SPI transmitter.
package kbtx_pkg;

  localparam int NUM_KEYS = 40;
  localparam int KEY_W    = 6;

  typedef enum logic [2:0] {
    KBTX_IDLE  = 3'd0,
    KBTX_SETUP = 3'd1,
    KBTX_SHIFT = 3'd2,
    KBTX_HOLD  = 3'd3,
    KBTX_GAP   = 3'd4
  } kbtx_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic key_in_range(input logic [KEY_W-1:0] key);
    return key < KEY_W'(NUM_KEYS);
  endfunction

endpackage

// File: rtl/kbtx_rr_arb.sv
// Two-source round-robin arbiter: grants at most one key event per cycle,
// alternating between sources while both are requesting.
module kbtx_rr_arb
  import kbtx_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid_a,
  input  logic [KEY_W-1:0] i_key_a,
  input  logic             i_press_a,
  input  logic             i_valid_b,
  input  logic [KEY_W-1:0] i_key_b,
  input  logic             i_press_b,
  input  logic             i_all_up,
  output logic             o_ready_a,
  output logic             o_ready_b,
  output logic             o_grant,
  output logic [KEY_W-1:0] o_key,
  output logic             o_press
);

  logic r_rr;
  logic w_ready_a;
  logic w_ready_b;
  logic w_both;

  assign w_both = i_valid_a && i_valid_b;

  // Grant decision; a matrix clear blocks both sources for its cycle.
  always_comb begin
    w_ready_a = 1'b0;
    w_ready_b = 1'b0;
    if (!i_rst_n || i_all_up) begin
      w_ready_a = 1'b0;
      w_ready_b = 1'b0;
    end else if (w_both) begin
      w_ready_a = (r_rr == SRC_A);
      w_ready_b = (r_rr == SRC_B);
    end else begin
      w_ready_a = i_valid_a;
      w_ready_b = i_valid_b;
    end
  end

  // Round-robin pointer flips only on contended grants.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr <= SRC_A;
    end else if (w_both && !i_all_up) begin
      r_rr <= ~r_rr;
    end
  end

  assign o_ready_a = w_ready_a;
  assign o_ready_b = w_ready_b;
  assign o_grant   = w_ready_a || w_ready_b;
  assign o_key     = w_ready_b ? i_key_b : i_key_a;
  assign o_press   = w_ready_b ? i_press_b : i_press_a;

endmodule

// File: rtl/kbmatrix_spi_tx.sv
// Live 5x8 key matrix fed by two arbitrated sources and shipped as a 40-bit SPI frame.
// Define KBTX_REFRESH_EN to also send a frame after REFRESH_CYC idle cycles.
module kbmatrix_spi_tx
  import kbtx_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int REFRESH_CYC = 1_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid_a,
  input  logic [KEY_W-1:0] i_key_a,
  input  logic             i_press_a,
  output logic             o_ready_a,
  input  logic             i_valid_b,
  input  logic [KEY_W-1:0] i_key_b,
  input  logic             i_press_b,
  output logic             o_ready_b,
  input  logic             i_all_up,
  output logic             o_spi_clk,
  output logic             o_spi_cs,
  output logic             o_spi_mosi,
  output logic             o_busy
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [2:0] S_IDLE  = KBTX_IDLE;
  localparam logic [2:0] S_SETUP = KBTX_SETUP;
  localparam logic [2:0] S_SHIFT = KBTX_SHIFT;
  localparam logic [2:0] S_HOLD  = KBTX_HOLD;
  localparam logic [2:0] S_GAP   = KBTX_GAP;

  logic                w_grant;
  logic                w_press;
  logic [KEY_W-1:0]    w_key;
  logic                w_key_ok;
  logic                w_start;
  logic                w_div_end;
  logic                w_gap_end;
  logic                w_refresh_hit;
  logic [NUM_KEYS-1:0] r_matrix;
  logic [NUM_KEYS-1:0] r_shift;
  logic                r_dirty;
  logic [2:0]          r_state;
  logic [DIV_W-1:0]    r_div;
  logic [KEY_W-1:0]    r_bit;
  logic                r_cs;
  logic                r_sck;
  logic                r_mosi;
  logic                r_busy;

  kbtx_rr_arb u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid_a (i_valid_a),
    .i_key_a   (i_key_a),
    .i_press_a (i_press_a),
    .i_valid_b (i_valid_b),
    .i_key_b   (i_key_b),
    .i_press_b (i_press_b),
    .i_all_up  (i_all_up),
    .o_ready_a (o_ready_a),
    .o_ready_b (o_ready_b),
    .o_grant   (w_grant),
    .o_key     (w_key),
    .o_press   (w_press)
  );

  assign w_key_ok  = key_in_range(w_key);
  assign w_start   = (r_state == S_IDLE) && (r_dirty || w_refresh_hit);
  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_gap_end = (r_div == DIV_W'(2 * CLK_DIV - 1));

  // A new event marks the matrix dirty even in the cycle a snapshot is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_matrix <= '0;
      r_dirty  <= 1'b0;
    end else if (i_all_up) begin
      r_matrix <= '0;
      r_dirty  <= 1'b1;
    end else if (w_grant && w_key_ok) begin
      r_matrix[w_key] <= w_press;
      r_dirty         <= 1'b1;
    end else if (w_start) begin
      r_dirty <= 1'b0;
    end
  end

`ifdef KBTX_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_CYC + 1);
  logic [REF_W-1:0] r_refresh;

  assign w_refresh_hit = (r_refresh == REF_W'(REFRESH_CYC - 1));

  // Counts idle cycles since the last frame; held at zero while a frame runs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_refresh <= '0;
    end else if (r_state == S_IDLE && !w_start) begin
      r_refresh <= r_refresh + REF_W'(1);
    end else begin
      r_refresh <= '0;
    end
  end
`else
  // Never true; keeps REFRESH_CYC referenced so both builds share one parameter list.
  assign w_refresh_hit = (REFRESH_CYC < 0);
`endif

  // Frame sequencer: key 0 leaves first; MOSI advances on each SCK fall.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_cs    <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_SETUP;
            r_shift <= r_matrix;
            r_bit   <= '0;
            r_div   <= '0;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_state <= S_SHIFT;
            r_div   <= '0;
            r_mosi  <= r_shift[0];
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + DIV_W'(1);
          end else if (!r_sck) begin
            r_div <= '0;
            r_sck <= 1'b1;
          end else begin
            r_div <= '0;
            r_sck <= 1'b0;
            if (r_bit == KEY_W'(NUM_KEYS - 1)) begin
              r_state <= S_HOLD;
              r_mosi  <= 1'b0;
            end else begin
              r_bit   <= r_bit + KEY_W'(1);
              r_shift <= {1'b0, r_shift[NUM_KEYS-1:1]};
              r_mosi  <= r_shift[1];
            end
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_state <= S_GAP;
            r_div   <= '0;
            r_cs    <= 1'b1;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_div   <= '0;
          r_cs    <= 1'b1;
          r_sck   <= 1'b0;
          r_mosi  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_spi_cs   = r_cs;
  assign o_spi_clk  = r_sck;
  assign o_spi_mosi = r_mosi;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_kbmatrix_spi_tx.sv
// Bench for kbmatrix_spi_tx: a timeline model predicts every output each cycle,
// and a receiver model plus literal frame values pin the directed scenarios.
module tb_kbmatrix_spi_tx;

  localparam int D       = 4;
  localparam int REF_CYC = 1000;
`ifdef KBTX_REFRESH_EN
  localparam bit REF_ON = 1'b1;
`else
  localparam bit REF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_a = 1'b0, press_a = 1'b0, valid_b = 1'b0, press_b = 1'b0;
  logic       all_up = 1'b0;
  logic [5:0] key_a = 6'd0, key_b = 6'd0;
  logic       ready_a, ready_b, spi_clk, spi_cs, spi_mosi, busy;

  kbmatrix_spi_tx #(.CLK_DIV(D), .REFRESH_CYC(REF_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid_a(valid_a), .i_key_a(key_a), .i_press_a(press_a), .o_ready_a(ready_a),
    .i_valid_b(valid_b), .i_key_b(key_b), .i_press_b(press_b), .o_ready_b(ready_b),
    .i_all_up(all_up),
    .o_spi_clk(spi_clk), .o_spi_cs(spi_cs), .o_spi_mosi(spi_mosi), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Model state: t is the offset since CS fell (-1 while idle).
  typedef struct {
    logic [39:0] mat;
    logic [39:0] snap;
    logic        dirty;
    logic        rr;
    int          t;
    int          ref_cnt;
  } mstate_t;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.mat = 40'd0; s.snap = 40'd0; s.dirty = 1'b0; s.rr = 1'b0; s.t = -1; s.ref_cnt = 0;
    return s;
  endfunction

  function automatic logic [1:0] exp_ready(input logic rr, input logic va, input logic vb,
                                           input logic au, input logic rn);
    if (!rn || au) return 2'b00;
    if (va && vb) return rr ? 2'b01 : 2'b10;
    return {va, vb};
  endfunction

  // {cs, sck, mosi, busy} as a function of time into the frame.
  function automatic logic [3:0] exp_out(input mstate_t s);
    int u;
    if (s.t < 0) return 4'b1000;
    if (s.t < D) return 4'b0001;
    if (s.t < 81 * D) begin
      u = s.t - D;
      return {1'b0, ((u % (2 * D)) >= D), s.snap[u / (2 * D)], 1'b1};
    end
    if (s.t < 82 * D) return 4'b0001;
    return 4'b1001;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic va, input logic [5:0] ka,
                                   input logic pa, input logic vb, input logic [5:0] kb,
                                   input logic pb, input logic au);
    mstate_t n;
    logic [1:0] g;
    logic start, set;
    n = s;
    g = exp_ready(s.rr, va, vb, au, 1'b1);
    start = (s.t < 0) && (s.dirty || (REF_ON && s.ref_cnt == REF_CYC - 1));
    set = 1'b0;
    if (au) begin
      n.mat = 40'd0; set = 1'b1;
    end else if (g[1] && ka < 6'd40) begin
      n.mat[ka] = pa; set = 1'b1;
    end else if (g[0] && kb < 6'd40) begin
      n.mat[kb] = pb; set = 1'b1;
    end
    if (va && vb && !au) n.rr = !s.rr;
    if (start) begin
      n.snap = s.mat; n.t = 0; n.ref_cnt = 0;
    end else if (s.t >= 0) begin
      n.t = (s.t + 1 == 84 * D) ? -1 : s.t + 1;
    end else begin
      n.ref_cnt = s.ref_cnt + 1;
    end
    n.dirty = set ? 1'b1 : (start ? 1'b0 : s.dirty);
    return n;
  endfunction

  mstate_t ms;
  logic    m_ok = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      ms   <= reset_state();
      m_ok <= 1'b1;
    end else begin
      ms <= step(ms, valid_a, key_a, press_a, valid_b, key_b, press_b, all_up);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_ok)
      chk("cycle_out{cs,sck,mosi,busy,rdy_a,rdy_b}",
          {58'd0, spi_cs, spi_clk, spi_mosi, busy, ready_a, ready_b},
          {58'd0, exp_out(ms), exp_ready(ms.rr, valid_a, valid_b, all_up, rst_n)});
  end

  // Receiver model: shift in the MOSI value held during SCK high at each SCK fall.
  logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0, held = 1'b0;
  logic [39:0] rx_data = 40'd0;
  int          rx_falls = 0;
  int          n_cs = 0, n_done = 0, n_bf = 0;
  int          cs_cyc[64];
  int          bf_cyc[64];
  int          fr_falls[64];
  logic [39:0] fr_data[64];

  always @(negedge clk) begin
    prev_sck  <= spi_clk;
    prev_cs   <= spi_cs;
    prev_busy <= busy;
    if (spi_clk === 1'b1) held <= spi_mosi;
    if (prev_cs === 1'b1 && spi_cs === 1'b0) begin
      rx_data  <= 40'd0;
      rx_falls <= 0;
      if (n_cs < 64) cs_cyc[n_cs] <= cyc;
      n_cs <= n_cs + 1;
    end else if (prev_sck === 1'b1 && spi_clk === 1'b0 && spi_cs === 1'b0) begin
      rx_data  <= {rx_data[38:0], held};
      rx_falls <= rx_falls + 1;
    end
    if (prev_cs === 1'b0 && spi_cs === 1'b1) begin
      if (n_done < 64) begin
        fr_data[n_done]  <= rx_data;
        fr_falls[n_done] <= rx_falls;
      end
      n_done <= n_done + 1;
    end
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (n_bf < 64) bf_cyc[n_bf] <= cyc;
      n_bf <= n_bf + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; all_up = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic event_a(input logic [5:0] k, input logic p, input logic exp_rdy);
    valid_a = 1'b1; key_a = k; press_a = p;
    @(negedge clk);
    chk("ready_a_event", {63'd0, ready_a}, {63'd0, exp_rdy});
    @(posedge clk);
    #1;
    valid_a = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while ((n_done < target || busy !== 1'b0) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("frame_wait_timeout", {63'd0, (k >= budget)}, 64'd0);
    tick(2);
  endtask

  int bc, bd, bb;
  logic [3:0] pat_a;

  initial begin
    // Idle after reset: no frame at all.
    do_reset();
    bc = n_cs;
    tick(1000);
    chk("idle_frames", n_cs - bc, 64'd0);
    chk("idle_cs", {63'd0, spi_cs}, 64'd1);
    chk("idle_sck", {63'd0, spi_clk}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Single key 0 press: one 336-cycle frame, key 0 lands in data[39].
    do_reset();
    bc = n_cs; bd = n_done; bb = n_bf;
    event_a(6'd0, 1'b1, 1'b1);
    wait_frames(bd + 1, 2000);
    chk("k0_frames", n_cs - bc, 64'd1);
    chk("k0_falls", fr_falls[bd], 64'd40);
    chk("k0_data", {24'd0, fr_data[bd]}, {24'd0, 40'h80_0000_0000});
    chk("k0_len", bf_cyc[bb] - cs_cyc[bc], 64'd336);

    // Contended sources: grants alternate A, B, A, B.
    do_reset();
    bd = n_done;
    pat_a = 4'b0101;
    valid_a = 1'b1; key_a = 6'd5; press_a = 1'b1;
    valid_b = 1'b1; key_b = 6'd9; press_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_ready_a", {63'd0, ready_a}, {63'd0, pat_a[i]});
      chk("rr_ready_b", {63'd0, ready_b}, {63'd0, ~pat_a[i]});
      @(posedge clk);
      #1;
    end
    valid_a = 1'b0; valid_b = 1'b0;
    wait_frames(bd + 2, 3000);
    chk("rr_frame1", {24'd0, fr_data[bd]}, {24'd0, 40'h04_0000_0000});
    chk("rr_frame2", {24'd0, fr_data[bd + 1]}, {24'd0, 40'h04_4000_0000});

    // Key 39 pressed mid-frame: snapshot untouched, follow-up frame right after GAP.
    do_reset();
    bc = n_cs; bd = n_done;
    event_a(6'd3, 1'b1, 1'b1);
    tick(150);
    event_a(6'd39, 1'b1, 1'b1);
    wait_frames(bd + 2, 3000);
    chk("mid_frame1", {24'd0, fr_data[bd]}, {24'd0, 40'h10_0000_0000});
    chk("mid_frame2", {24'd0, fr_data[bd + 1]}, {24'd0, 40'h10_0000_0001});
    chk("mid_cs_spacing", cs_cyc[bc + 1] - cs_cyc[bc], 64'd337);

    // Out-of-range key is accepted and dropped; ALL_UP wins over a valid source.
    do_reset();
    bc = n_cs;
    event_a(6'd45, 1'b1, 1'b1);
    tick(400);
    chk("bad_key_frames", n_cs - bc, 64'd0);
    bd = n_done;
    event_a(6'd7, 1'b1, 1'b1);
    wait_frames(bd + 1, 2000);
    chk("k7_data", {24'd0, fr_data[bd]}, {24'd0, 40'h01_0000_0000});
    all_up = 1'b1;
    event_a(6'd7, 1'b1, 1'b0);
    all_up = 1'b0;
    wait_frames(bd + 2, 2000);
    chk("allup_data", {24'd0, fr_data[bd + 1]}, 64'd0);
    chk("allup_falls", fr_falls[bd + 1], 64'd40);

    // Reset 20 bits into a frame: line idles on the very next edge, nothing trails.
    do_reset();
    event_a(6'd0, 1'b1, 1'b1);
    for (int k = 0; k < 2000 && rx_falls < 20; k++) tick(1);
    chk("rst_reached_bit20", {63'd0, (rx_falls >= 20)}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cs", {63'd0, spi_cs}, 64'd1);
    chk("rst_sck", {63'd0, spi_clk}, 64'd0);
    chk("rst_mosi", {63'd0, spi_mosi}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bc = n_cs;
    tick(400);
    chk("rst_no_frame", n_cs - bc, 64'd0);

`ifdef KBTX_REFRESH_EN
    // Refresh: zero frames recur every 1000 idle cycles.
    do_reset();
    bc = n_cs; bd = n_done;
    tick(3000);
    chk("ref_count", {63'd0, (n_cs - bc >= 2)}, 64'd1);
    chk("ref_data", {24'd0, fr_data[bd + 1]}, 64'd0);
    chk("ref_spacing", cs_cyc[bc + 1] - cs_cyc[bc], 64'd1336);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kbmatrix_spi_tx.md
# kbmatrix_spi_tx

SPI master and event scheduler that feeds the 5x8 ZX Spectrum keyboard-matrix SPI receiver. Two key-event sources share one 40-bit live matrix through a round-robin arbiter. The block snapshots the matrix and shifts it out as a 40-bit SPI frame whenever it changes, and periodically when refresh is compiled in. It sits on the host side of the SPI link, between the USB-HID/joystick event logic and the matrix receiver.

## Interface
- CLK_DIV, 4: SCK half-period in CLK cycles; must be ≥2.
- REFRESH_CYC, 1_000_000: CLK cycles between forced refresh frames. Used only with KBTX_REFRESH_EN.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- VALID_A  in  1  source A (USB HID) event valid.
- KEY_A  in  6  source A key index, 0..39; index = row*8 + col, row = KL line, col = BA bit.
- PRESS_A  in  1  1 = press, 0 = release.
- READY_A  out  1  source A event accepted this cycle.
- VALID_B, KEY_B, PRESS_B, READY_B: same for source B (joystick/macro).
- ALL_UP  in  1  single-cycle pulse; clears the whole matrix; takes priority over both sources that cycle.
- SPI_CLK  out  1  serial clock; idles low.
- SPI_CS  out  1  frame select, active-low; receiver drives KL only while high.
- SPI_MOSI  out  1  serial data, MSB first.
- BUSY  out  1  high from frame start through end of inter-frame gap.

## Operation
- Live matrix: 40 bits, 1 = key down. An accepted event sets or clears bit KEY and sets `dirty`. KEY ≥ 40 is accepted (READY=1) and dropped; the matrix and `dirty` are unchanged.
- Arbitration: at most one event per cycle. If only one source is valid, it is granted. If both are valid, the `rr` pointer decides; `rr` toggles after every grant while both sources are valid. `rr` resets to A. READY_x is combinational from VALID_x, the other source's VALID, `rr`, and ALL_UP; READY_x=0 while ALL_UP=1. Events are accepted in every FSM state.
- ALL_UP clears all 40 bits and sets `dirty`.
- FSM states:
  - IDLE: moves to SETUP when `dirty` is set or the refresh timer expires. On the transition the live matrix is copied to the shift register and `dirty` is cleared in the same cycle.
  - SETUP: CS low; lasts CLK_DIV cycles.
  - SHIFT: 40 bits. For each bit, MOSI is presented with SCK low for CLK_DIV cycles, then SCK is high for CLK_DIV cycles. The falling SCK edge is the receiver's sample point.
  - HOLD: SCK low, CS low; lasts CLK_DIV cycles.
  - GAP: CS high; lasts 2*CLK_DIV cycles; returns to IDLE.
- Bit order: the first bit shifted is key 0 (KL0/BA0); the last is key 39 (KL4/BA7). After 40 falling edges, the receiver's data[39] holds key 0.
- Events accepted during a frame do not change the snapshot. They set `dirty`, and a new frame starts on the first IDLE cycle after GAP.
- Bit counter: 6 bits, counts 0..39; the 40th falling edge moves the FSM to HOLD. The divider counter is log2(CLK_DIV)+1 bits and reloads on every phase change.

## Timing
- Reset values: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, BUSY=0, READY_A=READY_B=0, matrix all 0, `dirty`=0, `rr`=A, FSM in IDLE, refresh timer 0.
- Reset asserted mid-frame: on the next CLK edge CS=1, SCK=0, MOSI=0, and all reset values apply. No partial trailing edges are generated.
- Event latency: an event accepted in cycle n appears in the matrix at n+1. If the FSM is in IDLE, CS falls at n+2.
- Frame length: CLK_DIV + 80*CLK_DIV + CLK_DIV + 2*CLK_DIV = 84*CLK_DIV cycles from CS falling to the return to IDLE.
- MOSI changes only while SCK is low, and is stable for CLK_DIV cycles before each falling edge.
- BUSY=1 exactly while the FSM is not in IDLE.

## Configuration
- KBTX_REFRESH_EN defined: a refresh timer counts CLK cycles in IDLE and reloads at every frame start. On reaching REFRESH_CYC, a frame is sent even if `dirty` is clear. This guards against receiver corruption from SCK glitches.
- KBTX_REFRESH_EN undefined: there is no timer, and frames are sent only when `dirty` is set.

## Structure
- Package kbtx_pkg: NUM_KEYS=40, KEY_W=6, FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP), source-select constants SRC_A/SRC_B.
- Sub-module kbtx_rr_arb: two-requester round-robin arbiter producing READY_A/READY_B and the selected key/press pair. The FSM, matrix, divider and shifter stay in kbmatrix_spi_tx.

## Test plan
- Reset then idle for 1000 cycles -> CS stays 1, SCK stays 0, no frame, BUSY=0.
- CLK_DIV=4; A presses key 0 -> one frame with exactly 40 SCK falls; MOSI=1 only at the 1st fall; frame is 336 cycles; bench receiver model data = 40'h80_0000_0000.
- A and B both valid for 4 cycles with keys 5, 9, 5, 9 -> grants alternate A, B, A, B; final matrix has bits 5 and 9 set.
- A presses key 39 in the middle of a frame -> the current frame is unchanged; a second frame starts right after GAP with the last bit = 1.
- KEY_A=45 with VALID_A -> READY_A=1, no frame, matrix unchanged; then ALL_UP with VALID_A -> READY_A=0, matrix cleared, one frame of 40 zeros.
- Reset asserted 20 SCK bits into a frame -> CS=1, SCK=0 the next cycle; with KBTX_REFRESH_EN and REFRESH_CYC=1000, a zero frame follows every 1000 idle cycles.
